// File: rtl/connector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : connector_pkg
//  Description : Shared constants and types for the three-channel connector
//                transmitter (channel count, data width, channel index type).
//  Revision    : 1.0  initial release
// ============================================================================
package connector_pkg;

   localparam int CH_NUM = 3;
   localparam int DATA_W = 8;

   typedef logic [1:0] chan_t;

   // The only channel index that has no FIFO behind it.
   localparam chan_t c_chan_illegal = 2'd3;

   function automatic logic chan_legal(input chan_t c);
      return (c != c_chan_illegal);
   endfunction

endpackage
`default_nettype wire

// File: rtl/connector_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : connector_tx_fifo
//  Description : Single-channel byte FIFO with registered occupancy count.
//                Full/empty come straight from the count register, so they
//                reflect the state before any same-cycle push or pop.
//  Revision    : 1.0  initial release
// ============================================================================
module connector_tx_fifo
   import connector_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic              clk0,
   input  logic              resetn,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int              c_aw       = $clog2(DEPTH);
   localparam logic [c_aw:0]   c_full_cnt = (c_aw+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [c_aw-1:0]   r_wptr;
   logic [c_aw-1:0]   r_rptr;
   logic [c_aw:0]     r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign full      = (r_count == c_full_cnt);
   assign empty     = (r_count == '0);
   assign head      = r_mem[r_rptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Storage array; contents are meaningless while the count says empty.
   always_ff @(posedge clk0) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= push_data;
      end
   end

   // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
   always_ff @(posedge clk0 or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/connector_tx_part3.sv
`default_nettype none
// ============================================================================
//  Module      : connector_tx_part3
//  Description : Three-channel transmit connector. A local source pushes bytes
//                into per-channel FIFOs; each channel drains independently as
//                a one-cycle write strobe with registered data. A freeze input
//                halts all draining while queuing continues.
//                Optional macro CONNECTOR_TX_GAP_EN adds a 'gap' input that
//                forces idle cycles between beats on the same channel.
//  Revision    : 1.0  initial release
// ============================================================================
module connector_tx_part3
   import connector_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int GAP_W = 4
)(
   input  logic              clk0,
   input  logic              resetn,
   input  logic              push,
   input  chan_t             push_chan,
   input  logic [DATA_W-1:0] push_data,
   output logic              push_ready,
   input  logic              freeze,
`ifdef CONNECTOR_TX_GAP_EN
   input  logic [GAP_W-1:0]  gap,
`endif
   output logic              wen0,
   output logic              wen1,
   output logic              wen2,
   output logic [DATA_W-1:0] data0,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic              busy,
   output logic              err
);

   // Reject nonsensical configurations at elaboration time.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_W < 1) begin : g_param_check
      $error("connector_tx_part3: DEPTH must be a power of two >= 2 and GAP_W >= 1");
   end

   logic [CH_NUM-1:0] w_full;
   logic [CH_NUM-1:0] w_empty;
   logic [CH_NUM-1:0] w_push;
   logic [CH_NUM-1:0] w_pop;
   logic [CH_NUM-1:0] w_gap_idle;
   logic [DATA_W-1:0] w_head [CH_NUM];
   logic [3:0]        w_full_idx;
   logic              w_legal;

   logic [CH_NUM-1:0] r_wen;
   logic [DATA_W-1:0] r_data [CH_NUM];
   logic              r_busy;
   logic              r_err;

   // Full flags indexed by the raw 2-bit channel; the illegal slot reads full.
   assign w_full_idx = {1'b1, w_full};
   assign w_legal    = chan_legal(push_chan);
   assign push_ready = w_legal && !w_full_idx[push_chan];

   for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_chan
      assign w_push[ch] = push && push_ready && (push_chan == chan_t'(ch));
      assign w_pop[ch]  = !w_empty[ch] && !freeze && w_gap_idle[ch];

      connector_tx_fifo #(
         .DEPTH     (DEPTH)
      ) u_fifo (
         .clk0      (clk0),
         .resetn    (resetn),
         .push      (w_push[ch]),
         .pop       (w_pop[ch]),
         .push_data (push_data),
         .full      (w_full[ch]),
         .empty     (w_empty[ch]),
         .head      (w_head[ch])
      );

`ifdef CONNECTOR_TX_GAP_EN
      logic [GAP_W-1:0] r_gap_cnt;

      // Reload the spacing counter on each pop, then drain it once per cycle.
      always_ff @(posedge clk0 or negedge resetn) begin
         if (!resetn) begin
            r_gap_cnt <= '0;
         end else if (w_pop[ch]) begin
            r_gap_cnt <= gap;
         end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end
      end

      assign w_gap_idle[ch] = (r_gap_cnt == '0);
`else
      assign w_gap_idle[ch] = 1'b1;
`endif
   end

   // Register strobes, data, error pulse and the busy summary.
   always_ff @(posedge clk0 or negedge resetn) begin
      if (!resetn) begin
         r_wen  <= '0;
         r_busy <= 1'b0;
         r_err  <= 1'b0;
         for (int ch = 0; ch < CH_NUM; ch++) begin
            r_data[ch] <= '0;
         end
      end else begin
         r_wen  <= w_pop;
         r_busy <= ~&w_empty;
         r_err  <= push && !w_legal;
         for (int ch = 0; ch < CH_NUM; ch++) begin
            if (w_pop[ch]) begin
               r_data[ch] <= w_head[ch];
            end
         end
      end
   end

   assign wen0  = r_wen[0];
   assign wen1  = r_wen[1];
   assign wen2  = r_wen[2];
   assign data0 = r_data[0];
   assign data1 = r_data[1];
   assign data2 = r_data[2];
   assign busy  = r_busy;
   assign err   = r_err;

endmodule
`default_nettype wire
